// File: rtl/router_pkg.sv
//------------------------------------------------------------------------------
// Module   : router_pkg
// Purpose  : Shared types for the router receive path: receive FSM state
//            encoding, destination address width and the FIFO entry format.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package router_pkg;

  // Destination address width (16 output ports).
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAD     = 2'd2,
    PAYLOAD = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [ADDR_W-1:0] dest;
    logic [7:0]        data;
  } rx_entry_t;

endpackage

`default_nettype wire

// File: rtl/router_rx_fifo.sv
//------------------------------------------------------------------------------
// Module   : router_rx_fifo
// Purpose  : Synchronous FIFO of rx_entry_t. A write while full succeeds when
//            a read retires the head on the same edge.
// Ports    : clk, reset_n (async active-low)
//            wr_en/wr_data  - push request and entry
//            full           - no free slot (before any same-edge read)
//            rd_en/rd_data  - pop request and head entry (show-ahead)
//            empty          - no valid entry
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module router_rx_fifo
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      wr_en,
  input  rx_entry_t wr_data,
  output logic      full,
  input  logic      rd_en,
  output rx_entry_t rd_data,
  output logic      empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rx_entry_t   mem_q [FIFO_DEPTH];
  logic        rd_fire;
  logic        wr_fire;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/router_in_deser.sv
//------------------------------------------------------------------------------
// Module   : router_in_deser
// Purpose  : Per-input-port receive engine. Deserialises the serial
//            din/frame_n/valid_n packet protocol (address, pad, payload),
//            tags each byte with destination and SOP/EOP, and buffers it in
//            a FIFO drained by the crossbar through m_valid/m_ready.
// Ports    : clk, reset_n (async active-low)
//            din, frame_n, valid_n      - serial packet input, LSB first
//            m_valid/m_ready            - head entry handshake
//            m_data, m_dest, m_sop, m_eop - head entry fields (0 when empty)
//            pkt_err                    - one-cycle pulse on protocol abort
//            drop_cnt                   - saturating count of bytes lost to full
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module router_in_deser
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int PAD_CYCLES = 5,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  din,
  input  logic                  frame_n,
  input  logic                  valid_n,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic [ADDR_W-1:0]     m_dest,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  pkt_err,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int ACW = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int PCW = $clog2(PAD_CYCLES + 1);

  rx_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ACW-1:0]        addr_cnt_q, addr_cnt_d;
  logic [PCW-1:0]        pad_cnt_q, pad_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  sop_pend_q, sop_pend_d;
  logic                  pkt_err_q, pkt_err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic      wr_en;
  rx_entry_t wr_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_rd;
  logic      wr_room;
  rx_entry_t fifo_head;
  rx_entry_t head;

  assign fifo_rd = m_ready & ~fifo_empty;
  // A same-edge pop frees the slot, so a push into a full FIFO still lands.
  assign wr_room = ~fifo_full | fifo_rd;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_cnt_d = addr_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sop_pend_d = sop_pend_q;
    pkt_err_d  = 1'b0;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    wr_entry   = '0;

    unique case (state_q)
      IDLE: begin
        if (!frame_n) begin
          addr_d     = '0;
          addr_d[0]  = din;
          addr_cnt_d = ACW'(1);
          shift_d    = '0;
          bit_cnt_d  = '0;
          sop_pend_d = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (frame_n) begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          addr_d[addr_cnt_q] = din;
          if (addr_cnt_q == ACW'(ADDR_W - 1)) begin
            pad_cnt_d = '0;
            state_d   = PAD;
          end else begin
            addr_cnt_d = addr_cnt_q + ACW'(1);
          end
        end
      end
      PAD: begin
        if (frame_n) begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end else if (pad_cnt_q == PCW'(PAD_CYCLES - 1)) begin
          bit_cnt_d = '0;
          state_d   = PAYLOAD;
        end else begin
          pad_cnt_d = pad_cnt_q + PCW'(1);
        end
      end
      PAYLOAD: begin
        if (!valid_n) begin
          shift_d[bit_cnt_q] = din;
          if (bit_cnt_q == 3'd7) begin
            wr_en         = 1'b1;
            wr_entry.sop  = sop_pend_q;
            wr_entry.eop  = frame_n;
            wr_entry.dest = addr_q;
            wr_entry.data = shift_d;
            bit_cnt_d     = '0;
            if (frame_n) state_d = IDLE;
          end else if (frame_n) begin
            // Packet ended mid-byte: drop the partial byte.
            pkt_err_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (frame_n) begin
          pkt_err_d = 1'b1;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // SOP stays pending until a byte of the packet actually enters the FIFO.
    if (wr_en) begin
      if (wr_room) begin
        sop_pend_d = 1'b0;
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      addr_cnt_q <= '0;
      pad_cnt_q  <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sop_pend_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_cnt_q <= addr_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sop_pend_q <= sop_pend_d;
      pkt_err_q  <= pkt_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  router_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .empty   (fifo_empty)
  );

  assign head     = fifo_empty ? '0 : fifo_head;
  assign m_valid  = ~fifo_empty;
  assign m_data   = head.data;
  assign m_dest   = head.dest;
  assign m_sop    = head.sop;
  assign m_eop    = head.eop;
  assign pkt_err  = pkt_err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_router_in_deser.sv
//------------------------------------------------------------------------------
// Module   : tb_router_in_deser
// Purpose  : Scoreboard bench for router_in_deser. Stimulus pushes expected
//            FIFO entries {sop,eop,dest,data}; a monitor pops and compares
//            each entry the DUT hands over on m_valid & m_ready.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_router_in_deser;
  import router_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       din = 1'b0;
  logic       frame_n = 1'b1;
  logic       valid_n = 1'b1;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic [3:0] m_dest;
  logic       m_sop;
  logic       m_eop;
  logic       pkt_err;
  logic [7:0] drop_cnt;

  int vecs = 0;
  int errs = 0;
  int err_pulses = 0;
  int e0;
  logic [13:0] exp_q[$];
  logic [13:0] got;

  always #5 clk = ~clk;

  router_in_deser #(
    .FIFO_DEPTH (16),
    .PAD_CYCLES (5),
    .DROP_CNT_W (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .din      (din),
    .frame_n  (frame_n),
    .valid_n  (valid_n),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_dest   (m_dest),
    .m_sop    (m_sop),
    .m_eop    (m_eop),
    .pkt_err  (pkt_err),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: inputs change on negedge, so negedge+1 sees the handshake that
  // the next posedge will complete.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && m_valid && m_ready) begin
        got = {m_sop, m_eop, m_dest, m_data};
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_entry: got 0x%0h expected no entry", got);
        end else begin
          chk("fifo_head", {18'h0, got}, {18'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (pkt_err) err_pulses++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic cyc(input logic fr, input logic vn, input logic d);
    @(negedge clk);
    frame_n = fr;
    valid_n = vn;
    din     = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic push_exp(input logic s, input logic e, input logic [3:0] dst, input logic [7:0] dat);
    exp_q.push_back({s, e, dst, dat});
  endtask

  // Address LSB first, then pad; valid_n low with toggling din during pad
  // must have no effect.
  task automatic send_hdr(input logic [3:0] dst);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, dst[i]);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, i[0]);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input int gap_at,
                           input int gap_len, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) cyc(1'b0, 1'b1, ~d[i]);
      cyc(last && (i == 7), 1'b0, d[i]);
      if (rdy_last && i == 7) m_ready = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    m_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    m_ready = 1'b0;
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_mvalid"}, {31'h0, m_valid}, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mvalid", {31'h0, m_valid}, 0);
    chk("rst_pkterr", {31'h0, pkt_err}, 0);
    chk("rst_dropcnt", {24'h0, drop_cnt}, 0);
    chk("rst_mdata", {24'h0, m_data}, 0);
    chk("rst_msop", {31'h0, m_sop}, 0);
    reset_n = 1'b1;
    idle(2);

    // Basic two-byte packet and write latency
    e0 = err_pulses;
    push_exp(1'b1, 1'b0, 4'd5, 8'hA5);
    push_exp(1'b0, 1'b1, 4'd5, 8'h3C);
    send_hdr(4'd5);
    send_byte(8'hA5, 1'b0, -1, 0, 1'b0);
    chk("t1_pre_valid", {31'h0, m_valid}, 0);
    @(posedge clk);
    #1;
    chk("t1_latency", {31'h0, m_valid}, 1);
    send_byte(8'h3C, 1'b1, -1, 0, 1'b0);
    idle(1);
    drain("t1");
    chk("t1_no_err", err_pulses - e0, 0);

    // Same packet with gaps inside bytes
    e0 = err_pulses;
    push_exp(1'b1, 1'b0, 4'd5, 8'hA5);
    push_exp(1'b0, 1'b1, 4'd5, 8'h3C);
    send_hdr(4'd5);
    send_byte(8'hA5, 1'b0, 3, 1, 1'b0);
    send_byte(8'h3C, 1'b1, 5, 3, 1'b0);
    idle(1);
    drain("t2");
    chk("t2_no_err", err_pulses - e0, 0);

    // frame_n rises during PAD
    e0 = err_pulses;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("t3_err_hi", {31'h0, pkt_err}, 1);
    @(posedge clk);
    #1;
    chk("t3_err_lo", {31'h0, pkt_err}, 0);
    idle(2);
    chk("t3_pulses", err_pulses - e0, 1);
    chk("t3_fifo_empty", {31'h0, m_valid}, 0);

    // frame_n rises after 3 payload bits of the second byte
    e0 = err_pulses;
    push_exp(1'b1, 1'b0, 4'd6, 8'h11);
    send_hdr(4'd6);
    send_byte(8'h11, 1'b0, -1, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk("t3b_err_hi", {31'h0, pkt_err}, 1);
    idle(2);
    chk("t3b_pulses", err_pulses - e0, 1);
    drain("t3b");

    // Overflow: 18 bytes into a 16-entry FIFO, then push+pop while full
    for (int i = 0; i < 16; i++) push_exp(i == 0, 1'b0, 4'hA, 8'h20 + 8'(i));
    send_hdr(4'hA);
    for (int i = 0; i < 18; i++) send_byte(8'h20 + 8'(i), i == 17, -1, 0, 1'b0);
    idle(1);
    chk("t4_drop2", {24'h0, drop_cnt}, 2);
    chk("t4_full_valid", {31'h0, m_valid}, 1);
    push_exp(1'b1, 1'b1, 4'd9, 8'h77);
    send_hdr(4'd9);
    send_byte(8'h77, 1'b1, -1, 0, 1'b1);
    idle(1);
    m_ready = 1'b0;
    idle(1);
    chk("t4_no_drop", {24'h0, drop_cnt}, 2);
    drain("t4");

    // Reset mid-payload with a stale entry in the FIFO
    send_hdr(4'd3);
    send_byte(8'h42, 1'b1, -1, 0, 1'b0);
    send_hdr(4'd3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    frame_n = 1'b1;
    valid_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_rst_empty", {31'h0, m_valid}, 0);
    chk("t5_rst_drop", {24'h0, drop_cnt}, 0);
    chk("t5_rst_err", {31'h0, pkt_err}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    push_exp(1'b1, 1'b1, 4'd15, 8'hFF);
    send_hdr(4'd15);
    send_byte(8'hFF, 1'b1, -1, 0, 1'b0);
    idle(1);
    chk("t5_one_entry", {31'h0, m_valid}, 1);
    drain("t5");

    // Back-to-back packets
    e0 = err_pulses;
    push_exp(1'b1, 1'b1, 4'd2, 8'hC3);
    push_exp(1'b1, 1'b0, 4'd12, 8'h5A);
    push_exp(1'b0, 1'b1, 4'd12, 8'h96);
    send_hdr(4'd2);
    send_byte(8'hC3, 1'b1, -1, 0, 1'b0);
    send_hdr(4'd12);
    send_byte(8'h5A, 1'b0, -1, 0, 1'b0);
    send_byte(8'h96, 1'b1, -1, 0, 1'b0);
    idle(1);
    drain("t6");
    chk("t6_no_err", err_pulses - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
